uart_rx_fifo: RTL and testbench

Receive-side buffer between the UART receiver and the AHB-lite UART register interface. It captures each byte completed by the UART receiver and holds it in a first-word-fall-through FIFO. The AHB slave pops bytes on CPU reads of the data register. It also produces a level interrupt for the NVIC IRQ line, replacing the raw one-byte receive pulse so back-to-back bytes are no longer lost while the CPU is in an ISR.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo_fwft.sv | 62 ++++++
 rtl/uart_rx_fifo.sv | 90 +++++++++
 tb/tb_uart_rx_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the AHB-lite UART: byte width, default receive FIFO depth and
// register offsets decoded by the bus interface.
package uart_pkg;

   localparam int unsigned UART_BYTE_W   = 8;
   localparam int unsigned UART_RX_DEPTH = 16;
   localparam int unsigned UART_RX_AW    = 4;

   localparam logic [3:0] UART_REG_DATA   = 4'h0;
   localparam logic [3:0] UART_REG_STATUS = 4'h4;
   localparam logic [3:0] UART_REG_CTRL   = 4'h8;
   localparam logic [3:0] UART_REG_THRESH = 4'hC;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO. A pop of a full FIFO frees the slot for a push in
// the same cycle; a pop of an empty FIFO is ignored.
module sync_fifo_fwft #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              RSTn,
   input  logic              push,
   input  logic              pop,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata,
   output logic [ADDR_W:0]   count,
   output logic [ADDR_W:0]   count_next,
   output logic              full,
   output logic              empty
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]   count_q, count_d;
   logic              push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == DEPTH_C);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      count_d = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
         count_q <= count_d;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wdata;
   end

   assign rdata      = empty ? '0 : mem[rd_ptr_q];
   assign count      = count_q;
   assign count_next = count_d;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: strobe edge detect into an FWFT FIFO, sticky overrun, a clamped
// interrupt threshold and a registered level interrupt.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH      = UART_RX_DEPTH,
   parameter int unsigned ADDR_W     = UART_RX_AW,
   parameter int unsigned THRESH_RST = 1
) (
   input  logic                   clk,
   input  logic                   RSTn,
   input  logic [UART_BYTE_W-1:0] rx_data,
   input  logic                   rx_strobe,
   input  logic                   rd_en,
   input  logic                   thresh_wr,
   input  logic [ADDR_W:0]        thresh_din,
   input  logic                   ovr_clr,
   input  logic                   irq_en,
   output logic [UART_BYTE_W-1:0] rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [ADDR_W:0]        count,
   output logic                   overrun,
   output logic                   irq
);

   localparam logic [ADDR_W:0] DEPTH_C      = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_C        = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0] THRESH_RST_C = (ADDR_W + 1)'(THRESH_RST);

   logic            rx_strobe_q;
   logic            push, pop, overflow;
   logic [ADDR_W:0] count_next;
   logic [ADDR_W:0] thresh_q, thresh_d;
   logic            overrun_q, overrun_d;
   logic            irq_q, irq_d;

   // One push per strobe, however long the receiver holds it.
   assign push     = rx_strobe & ~rx_strobe_q;
   assign pop      = rd_en & ~empty;
   assign overflow = push & full & ~pop;

   sync_fifo_fwft #(
      .WIDTH  (UART_BYTE_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk        (clk),
      .RSTn       (RSTn),
      .push       (push),
      .pop        (rd_en),
      .wdata      (rx_data),
      .rdata      (rd_data),
      .count      (count),
      .count_next (count_next),
      .full       (full),
      .empty      (empty)
   );

   always_comb begin
      thresh_d = thresh_q;
      if (thresh_wr) begin
         if (thresh_din == '0)          thresh_d = ONE_C;
         else if (thresh_din > DEPTH_C) thresh_d = DEPTH_C;
         else                           thresh_d = thresh_din;
      end
   end

   // An overflow in the same cycle as a clear keeps the flag set.
   assign overrun_d = overflow | (overrun_q & ~ovr_clr);
   assign irq_d     = irq_en & ((count_next >= thresh_q) | overrun_d);

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         rx_strobe_q <= 1'b0;
         thresh_q    <= THRESH_RST_C;
         overrun_q   <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         rx_strobe_q <= rx_strobe;
         thresh_q    <= thresh_d;
         overrun_q   <= overrun_d;
         irq_q       <= irq_d;
      end
   end

   assign overrun = overrun_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       RSTn = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_strobe = 1'b0;
   logic       rd_en = 1'b0;
   logic       thresh_wr = 1'b0;
   logic [4:0] thresh_din = 5'd0;
   logic       ovr_clr = 1'b0;
   logic       irq_en = 1'b1;
   logic [7:0] rd_data;
   logic       empty, full, overrun, irq;
   logic [4:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .DEPTH      (16),
      .ADDR_W     (4),
      .THRESH_RST (1)
   ) dut (
      .clk        (clk),
      .RSTn       (RSTn),
      .rx_data    (rx_data),
      .rx_strobe  (rx_strobe),
      .rd_en      (rd_en),
      .thresh_wr  (thresh_wr),
      .thresh_din (thresh_din),
      .ovr_clr    (ovr_clr),
      .irq_en     (irq_en),
      .rd_data    (rd_data),
      .empty      (empty),
      .full       (full),
      .count      (count),
      .overrun    (overrun),
      .irq        (irq)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a byte queue plus flags, advanced on each active clock edge.
   byte unsigned mq[$];
   bit m_ovr = 0, m_irq = 0, m_sprev = 0;
   int m_thresh = 1;

   initial begin
      bit psh, pp, ovf;
      forever begin
         @(posedge clk or negedge RSTn);
         if (!RSTn) begin
            mq.delete();
            m_ovr = 0; m_irq = 0; m_sprev = 0; m_thresh = 1;
         end else begin
            psh = rx_strobe && !m_sprev;
            m_sprev = rx_strobe;
            pp = rd_en && (mq.size() > 0);
            ovf = 0;
            if (pp) void'(mq.pop_front());
            if (psh) begin
               if (mq.size() < DEPTH) mq.push_back(rx_data);
               else ovf = 1;
            end
            if (ovf) m_ovr = 1;
            else if (ovr_clr) m_ovr = 0;
            m_irq = irq_en && ((mq.size() >= m_thresh) || m_ovr);
            if (thresh_wr)
               m_thresh = (thresh_din == 0) ? 1 : ((int'(thresh_din) > DEPTH) ? DEPTH
                                                                              : int'(thresh_din));
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("m_count", count, mq.size());
         chk("m_empty", empty, mq.size() == 0);
         chk("m_full", full, mq.size() == DEPTH);
         chk("m_rd_data", rd_data, (mq.size() > 0) ? mq[0] : 8'h00);
         chk("m_overrun", overrun, m_ovr);
         chk("m_irq", irq, m_irq);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic push_b(input logic [7:0] b);
      @(negedge clk); rx_data = b; rx_strobe = 1'b1;
      @(negedge clk); rx_strobe = 1'b0;
   endtask

   task automatic pop_b();
      @(negedge clk); rd_en = 1'b1;
      @(negedge clk); rd_en = 1'b0;
   endtask

   task automatic wr_thresh(input logic [4:0] v);
      @(negedge clk); thresh_din = v; thresh_wr = 1'b1;
      @(negedge clk); thresh_wr = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_irq", irq, 0);
      RSTn = 1'b1;

      // Single byte, strobe held three cycles.
      @(negedge clk); rx_data = 8'hA5; rx_strobe = 1'b1;
      @(negedge clk);
      chk("single_count", count, 1);
      chk("single_data", rd_data, 8'hA5);
      chk("single_irq", irq, 1);
      repeat (2) @(negedge clk);
      rx_strobe = 1'b0;
      @(negedge clk);
      chk("single_once", count, 1);
      chk("single_empty", empty, 0);
      pop_b();
      chk("single_popped", empty, 1);

      // Fill, overflow, drain.
      for (int i = 0; i < 16; i++) push_b(8'(i));
      chk("fill_full", full, 1);
      chk("fill_count", count, 16);
      push_b(8'hFF);
      chk("fill_ovr", overrun, 1);
      chk("fill_ovr_count", count, 16);
      for (int i = 0; i < 16; i++) begin
         chk("fill_pop_data", rd_data, i);
         pop_b();
      end
      chk("drain_empty", empty, 1);
      chk("drain_rd_data", rd_data, 8'h00);
      @(negedge clk); ovr_clr = 1'b1;
      @(negedge clk); ovr_clr = 1'b0;
      chk("ovr_cleared", overrun, 0);

      // Wrap-around.
      for (int i = 0; i < 10; i++) push_b(8'(8'h10 + i));
      chk("wrap_count10", count, 10);
      for (int i = 0; i < 10; i++) pop_b();
      for (int i = 0; i < 10; i++) push_b(8'(8'h20 + i));
      chk("wrap_count10b", count, 10);
      for (int i = 0; i < 10; i++) begin
         chk("wrap_data", rd_data, 8'h20 + i);
         pop_b();
      end

      // Simultaneous push and pop at full, then at empty.
      for (int i = 0; i < 16; i++) push_b(8'(8'h30 + i));
      @(negedge clk); rx_data = 8'h55; rx_strobe = 1'b1; rd_en = 1'b1;
      @(negedge clk); rx_strobe = 1'b0; rd_en = 1'b0;
      chk("simul_full_ovr", overrun, 0);
      chk("simul_full_count", count, 16);
      for (int i = 0; i < 15; i++) pop_b();
      chk("simul_last", rd_data, 8'h55);
      pop_b();
      @(negedge clk); rx_data = 8'h66; rx_strobe = 1'b1; rd_en = 1'b1;
      @(negedge clk); rx_strobe = 1'b0; rd_en = 1'b0;
      chk("simul_empty_count", count, 1);
      chk("simul_empty_data", rd_data, 8'h66);
      pop_b();

      // Threshold, irq and overrun clear priority.
      wr_thresh(5'd4);
      for (int i = 0; i < 3; i++) push_b(8'(8'h40 + i));
      chk("thr_below", irq, 0);
      push_b(8'h43);
      chk("thr_at", irq, 1);
      pop_b();
      chk("thr_pop", irq, 0);
      for (int i = 0; i < 13; i++) push_b(8'(8'h44 + i));
      chk("thr_full", count, 16);
      @(negedge clk); rx_data = 8'hEE; rx_strobe = 1'b1; ovr_clr = 1'b1;
      @(negedge clk); rx_strobe = 1'b0; ovr_clr = 1'b0;
      chk("ovr_set_wins", overrun, 1);
      @(negedge clk); ovr_clr = 1'b1;
      @(negedge clk); ovr_clr = 1'b0;
      chk("ovr_clr", overrun, 0);
      for (int i = 0; i < 16; i++) pop_b();
      wr_thresh(5'd0);
      push_b(8'h61);
      chk("thr_zero_as_one", irq, 1);
      wr_thresh(5'd31);
      @(negedge clk);
      chk("thr_clamp_high", irq, 0);
      pop_b();

      // Reset mid-operation with count 7 and overrun set.
      for (int i = 0; i < 16; i++) push_b(8'(8'h80 + i));
      push_b(8'hFF);
      for (int i = 0; i < 9; i++) pop_b();
      chk("mid_count7", count, 7);
      chk("mid_ovr", overrun, 1);
      @(negedge clk); RSTn = 1'b0;
      #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_full", full, 0);
      chk("mid_rst_ovr", overrun, 0);
      chk("mid_rst_irq", irq, 0);
      chk("mid_rst_data", rd_data, 8'h00);
      @(negedge clk); RSTn = 1'b1;
      push_b(8'h77);
      chk("post_rst_data", rd_data, 8'h77);
      chk("post_rst_count", count, 1);
      chk("post_rst_irq", irq, 1);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
